// File: rtl/mc_hdr_pkg.sv
// Shared definitions for the memcached response-header transmit path:
// record layout, wire constants, FSM encoding and the beat formatter.
package mc_hdr_pkg;

    localparam int MC_DW         = 64;
    localparam int MC_HDR_W      = 176;
    localparam logic [7:0] MC_MAGIC_RESP = 8'h81;
    localparam int MC_HDR_BYTES  = 24;
    localparam int MC_HDR_BEATS  = 3;

    localparam int OPCODE_LSB    = 0;
    localparam int OPCODE_W      = 8;
    localparam int KEY_LEN_LSB   = 8;
    localparam int KEY_LEN_W     = 16;
    localparam int EXT_LEN_LSB   = 24;
    localparam int EXT_LEN_W     = 8;
    localparam int STATUS_LSB    = 32;
    localparam int STATUS_W      = 16;
    localparam int BODY_LEN_LSB  = 48;
    localparam int BODY_LEN_W    = 32;
    localparam int OPAQUE_LSB    = 80;
    localparam int OPAQUE_W      = 32;
    localparam int CAS_LSB       = 112;
    localparam int CAS_W         = 64;

    // First member lands in the MSBs, so opcode ends up at bit 0.
    typedef struct packed {
        logic [63:0] cas;
        logic [31:0] opaque;
        logic [31:0] body_len;
        logic [15:0] status;
        logic [7:0]  ext_len;
        logic [15:0] key_len;
        logic [7:0]  opcode;
    } mc_hdr_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_BEAT2 = 2'd3
    } mc_hdr_state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [63:0] bswap64(input logic [63:0] v);
        return {bswap32(v[31:0]), bswap32(v[63:32])};
    endfunction

    // Fields are big-endian on the wire while byte0 sits in tdata[7:0],
    // hence every multi-byte field is byte-swapped into its lane.
    function automatic logic [MC_DW-1:0] fmt_beat(input mc_hdr_rec_t rec, input logic [1:0] idx);
        logic [MC_DW-1:0] beat;
        case (idx)
            2'd0:    beat = {rec.status[7:0], rec.status[15:8], 8'h00, rec.ext_len,
                             rec.key_len[7:0], rec.key_len[15:8], rec.opcode, MC_MAGIC_RESP};
            2'd1:    beat = {bswap32(rec.opaque), bswap32(rec.body_len)};
            2'd2:    beat = bswap64(rec.cas);
            default: beat = '0;
        endcase
        return beat;
    endfunction

endpackage

// File: rtl/mc_resp_hdr_tx_if.sv
// Header FIFO read port plus the outgoing AXI-Stream, bundled for the transmitter.
interface mc_resp_hdr_tx_if
    import mc_hdr_pkg::*;
#(
    parameter int DW = 64
);
    logic                fifo_rd_en;
    logic [MC_HDR_W-1:0] fifo_dout;
    logic                fifo_empty;
    logic [DW-1:0]       m_axis_tdata;
    logic [DW/8-1:0]     m_axis_tkeep;
    logic                m_axis_tvalid;
    logic                m_axis_tready;
    logic                m_axis_tlast;

    modport master (
        output fifo_rd_en,
        input  fifo_dout,
        input  fifo_empty,
        output m_axis_tdata,
        output m_axis_tkeep,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tlast
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_dout,
        output fifo_empty,
        input  m_axis_tdata,
        input  m_axis_tkeep,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tlast
    );
endinterface

// File: rtl/mc_resp_hdr_tx.sv
// Drains response-header records from the header FIFO and emits each as a
// 3-beat, 24-byte memcached binary header on a 64-bit AXI-Stream.
module mc_resp_hdr_tx
    import mc_hdr_pkg::*;
#(
    parameter int DW    = 64,
    parameter int CNT_W = 32
)(
    input  logic             clk,
    input  logic             rst_,
    mc_resp_hdr_tx_if.master bus,
    output logic             body_pending,
    output logic [CNT_W-1:0] hdr_cnt
);

    mc_hdr_state_t    state_reg;
    mc_hdr_state_t    state_next;
    mc_hdr_rec_t      hdr_reg;
    mc_hdr_rec_t      fifo_rec;
    logic             body_pending_reg;
    logic [CNT_W-1:0] hdr_cnt_reg;
    logic             pop;
    logic             beat2_done;
    logic [1:0]       beat_idx;

    assign fifo_rec   = mc_hdr_rec_t'(bus.fifo_dout);
    assign beat2_done = (state_reg == ST_BEAT2) && bus.m_axis_tready;

    // A pop happens from IDLE or on the closing handshake of the previous
    // header; gating with rst_ keeps rd_en low while reset is held.
    always_comb begin
        pop = 1'b0;
        if (rst_ && !bus.fifo_empty)
            pop = (state_reg == ST_IDLE) || beat2_done;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_reg        <= ST_IDLE;
            hdr_reg          <= '0;
            body_pending_reg <= 1'b0;
            hdr_cnt_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (pop) begin
                hdr_reg          <= fifo_rec;
                body_pending_reg <= (fifo_rec.body_len != '0);
            end
            if (beat2_done)
                hdr_cnt_reg <= hdr_cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (pop) state_next = ST_BEAT0;
            ST_BEAT0: if (bus.m_axis_tready) state_next = ST_BEAT1;
            ST_BEAT1: if (bus.m_axis_tready) state_next = ST_BEAT2;
            ST_BEAT2: if (bus.m_axis_tready) state_next = pop ? ST_BEAT0 : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        beat_idx          = 2'd0;
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tdata  = '0;
        bus.m_axis_tlast  = 1'b0;
        bus.m_axis_tkeep  = {(DW/8){1'b1}};
        bus.fifo_rd_en    = pop;
        case (state_reg)
            ST_BEAT0: beat_idx = 2'd0;
            ST_BEAT1: beat_idx = 2'd1;
            ST_BEAT2: beat_idx = 2'd2;
            default:  beat_idx = 2'd0;
        endcase
        if (state_reg != ST_IDLE) begin
            bus.m_axis_tvalid = 1'b1;
            bus.m_axis_tdata  = fmt_beat(hdr_reg, beat_idx);
            bus.m_axis_tlast  = (state_reg == ST_BEAT2) && (hdr_reg.body_len == '0);
        end
    end

    assign body_pending = body_pending_reg;
    assign hdr_cnt      = hdr_cnt_reg;

endmodule

// File: tb/tb_mc_resp_hdr_tx.sv
// Scoreboard bench for mc_resp_hdr_tx: a byte-level wire model feeds an
// expected-beat queue, and a monitor pops and compares on every handshake.
module tb_mc_resp_hdr_tx;
    import mc_hdr_pkg::*;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        body_pending;
    logic [31:0] hdr_cnt;

    mc_resp_hdr_tx_if #(.DW(64)) bus ();

    mc_resp_hdr_tx #(.DW(64), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_         (rst_),
        .bus          (bus.master),
        .body_pending (body_pending),
        .hdr_cnt      (hdr_cnt)
    );

    always #5 clk = ~clk;

    beat_t        exp_q[$];
    logic [175:0] fifo_q[$];
    int           total = 0;
    int           bad = 0;
    logic [31:0]  exp_cnt = '0;
    int           pops = 0;
    int           pushed = 0;
    int           beat_idx = 0;
    int           run_len = 0;
    int           max_run = 0;
    bit           prev_stall = 1'b0;
    logic [63:0]  prev_data = '0;
    logic         prev_last = 1'b0;
    logic [63:0]  last_beats [3];
    logic         last_tlast = 1'b0;
    bit           rand_ready = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, act, req, $time);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    function automatic logic [175:0] mk_rec(input logic [7:0] opc, input logic [15:0] klen,
                                            input logic [7:0] elen, input logic [15:0] st,
                                            input logic [31:0] blen, input logic [31:0] opq,
                                            input logic [63:0] cas);
        return {cas, opq, blen, st, elen, klen, opc};
    endfunction

    task automatic refresh_fifo();
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.fifo_dout  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    // Reference: lay out the 24 wire bytes, then slice into little-endian lanes.
    task automatic push_rec(input logic [175:0] r);
        logic [7:0] b [24];
        beat_t      e;
        b[0] = 8'h81;
        b[1] = r[7:0];
        b[2] = r[23:16];
        b[3] = r[15:8];
        b[4] = r[31:24];
        b[5] = 8'h00;
        b[6] = r[47:40];
        b[7] = r[39:32];
        for (int k = 0; k < 4; k++) begin
            b[8 + k]  = r[79 - 8*k -: 8];
            b[12 + k] = r[111 - 8*k -: 8];
        end
        for (int k = 0; k < 8; k++) b[16 + k] = r[175 - 8*k -: 8];
        for (int n = 0; n < 3; n++) begin
            for (int j = 0; j < 8; j++) e.data[8*j +: 8] = b[8*n + j];
            e.last = (n == 2) && (r[79:48] == 32'd0);
            exp_q.push_back(e);
        end
        fifo_q.push_back(r);
        pushed++;
        refresh_fifo();
    endtask

    task automatic push_random();
        logic [31:0] blen;
        blen = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        push_rec(mk_rec(8'($urandom), 16'($urandom), 8'($urandom), 16'($urandom),
                        blen, $urandom, {$urandom, $urandom}));
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL %s: drain timeout, %0d beats outstanding, required 0", nm, exp_q.size());
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    // FIFO model: pop decided from the settled rd_en, applied just after the edge.
    initial begin
        bit do_pop;
        forever begin
            @(negedge clk);
            do_pop = bus.fifo_rd_en;
            @(posedge clk);
            #1;
            if (do_pop && fifo_q.size() > 0) begin
                pops++;
                void'(fifo_q.pop_front());
                refresh_fifo();
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.m_axis_tready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor
    initial begin
        beat_t e;
        bit    slot_ok;
        forever begin
            @(negedge clk);
            if (!rst_) begin
                beat_idx   = 0;
                prev_stall = 1'b0;
                run_len    = 0;
            end else begin
                if (bus.fifo_rd_en) begin
                    check("rd_en_while_empty", 64'(bus.fifo_empty), 64'd0);
                    slot_ok = !bus.m_axis_tvalid || (bus.m_axis_tready && beat_idx == 2);
                    check("rd_en_slot", 64'(slot_ok), 64'd1);
                end
                if (prev_stall) begin
                    check("stall_valid", 64'(bus.m_axis_tvalid), 64'd1);
                    check("stall_data", bus.m_axis_tdata, prev_data);
                    check("stall_last", 64'(bus.m_axis_tlast), 64'(prev_last));
                end
                if (bus.m_axis_tvalid) begin
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                    check("tkeep", 64'(bus.m_axis_tkeep), 64'hFF);
                    if (bus.m_axis_tready) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL extra_beat: got %h required no beat", bus.m_axis_tdata);
                        end else begin
                            e = exp_q.pop_front();
                            check("beat_data", bus.m_axis_tdata, e.data);
                            check("beat_last", 64'(bus.m_axis_tlast), 64'(e.last));
                        end
                        last_beats[beat_idx] = bus.m_axis_tdata;
                        if (beat_idx == 2) last_tlast = bus.m_axis_tlast;
                        beat_idx++;
                        if (beat_idx == 3) begin
                            beat_idx = 0;
                            exp_cnt  = exp_cnt + 32'd1;
                        end
                    end
                end else begin
                    run_len = 0;
                    check("idle_tdata", bus.m_axis_tdata, 64'd0);
                end
                prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
                prev_data  = bus.m_axis_tdata;
                prev_last  = bus.m_axis_tlast;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pops_before;
        bus.fifo_empty    = 1'b1;
        bus.fifo_dout     = '0;
        bus.m_axis_tready = 1'b1;

        // Reset state, with a record already waiting in the FIFO
        repeat (2) @(posedge clk);
        #1;
        push_rec(mk_rec(8'h01, 16'h0005, 8'h04, 16'h0000, 32'h0000_0010,
                        32'hDEAD_BEEF, 64'h0000_0000_0000_0007));
        @(negedge clk);
        check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check("rst_tdata", bus.m_axis_tdata, 64'd0);
        check("rst_tlast", 64'(bus.m_axis_tlast), 64'd0);
        check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        check("rst_body_pending", 64'(body_pending), 64'd0);
        check("rst_hdr_cnt", 64'(hdr_cnt), 64'd0);
        @(posedge clk);
        #1 rst_ = 1'b1;

        // 1: single record with a body
        wait_drain("t1", 50);
        check("t1_beat0", last_beats[0], 64'h0000_0004_0500_0181);
        check("t1_beat1", last_beats[1], 64'hEFBE_ADDE_1000_0000);
        check("t1_beat2", last_beats[2], 64'h0700_0000_0000_0000);
        check("t1_tlast", 64'(last_tlast), 64'd0);
        check("t1_body_pending", 64'(body_pending), 64'd1);
        check("t1_hdr_cnt", 64'(hdr_cnt), 64'd1);

        // 2: same record, no body
        @(posedge clk);
        #1;
        push_rec(mk_rec(8'h01, 16'h0005, 8'h04, 16'h0000, 32'h0,
                        32'hDEAD_BEEF, 64'h0000_0000_0000_0007));
        wait_drain("t2", 50);
        check("t2_tlast", 64'(last_tlast), 64'd1);
        check("t2_body_pending", 64'(body_pending), 64'd0);
        check("t2_hdr_cnt", 64'(hdr_cnt), 64'd2);

        // 3: back-to-back records must stream without bubbles
        @(posedge clk);
        #1;
        max_run     = 0;
        pops_before = pops;
        for (int i = 0; i < 4; i++) push_random();
        wait_drain("t3", 100);
        check("t3_run_len", 64'(max_run), 64'd12);
        check("t3_pops", 64'(pops - pops_before), 64'd4);
        check("t3_hdr_cnt", 64'(hdr_cnt), 64'd6);

        // 4: random backpressure over 100 records
        rand_ready = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 2) == 0) begin
                push_random();
                n++;
            end
        end
        wait_drain("t4", 5000);
        rand_ready = 1'b0;
        @(posedge clk);
        #1 bus.m_axis_tready = 1'b1;
        @(negedge clk);
        check("t4_hdr_cnt", 64'(hdr_cnt), 64'(exp_cnt));
        check("t4_pops", 64'(pops), 64'(pushed));

        // 5: reset asserted while beat1 is on the bus
        @(posedge clk);
        #1;
        push_random();
        n = 0;
        while (!bus.m_axis_tvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("t5_in_beat1", 64'(bus.m_axis_tvalid), 64'd1);
        bus.m_axis_tready = 1'b0;
        #2 rst_ = 1'b0;
        #1;
        check("t5_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check("t5_tdata", bus.m_axis_tdata, 64'd0);
        check("t5_hdr_cnt", 64'(hdr_cnt), 64'd0);
        check("t5_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        check("t5_body_pending", 64'(body_pending), 64'd0);
        exp_q.delete();
        exp_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b1;
        bus.m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_idle_rd_en", 64'(bus.fifo_rd_en), 64'd0);
            check("t5_idle_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        end

        // 6: counter wrap
        @(negedge clk);
        force dut.hdr_cnt_reg = 32'hFFFF_FFFF;
        #1 release dut.hdr_cnt_reg;
        #1;
        if (hdr_cnt === 32'hFFFF_FFFF) begin
            exp_cnt = 32'hFFFF_FFFF;
            @(posedge clk);
            #1;
            push_random();
            wait_drain("t6", 50);
            check("t6_hdr_cnt_wrap", 64'(hdr_cnt), 64'd0);
        end else begin
            $display("note: counter preset did not hold after release, wrap case skipped");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
